// File: rtl/stack_seq_pkg.sv
// Shared types for the stack sequencer:
// FSM state encoding and stack operation codes.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W1,
    S_W2,
    S_R1,
    S_R2,
    S_RCAP,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_t;

endpackage

// File: rtl/stack_sequencer.sv
// Stack sequencer: runs PUSH/POP/CALL/RET as short byte-wide memory
// sequences and reports SP update, PC load, popped byte and status.
// Ports: Clock/ResetN; Start, Op, DataIn, SPIn, RetAddr, Target,
// MemRdData in; Mem*, StackIn*, PC*, PopData, Busy/Done/Error out.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter logic [15:0] STACK_LIMIT = 16'h0100,
  parameter logic [15:0] STACK_TOP   = 16'h08FF
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [7:0]  DataIn,
  input  logic [15:0] SPIn,
  input  logic [15:0] RetAddr,
  input  logic [15:0] Target,
  input  logic [7:0]  MemRdData,
  output logic [15:0] MemAddr,
  output logic [7:0]  MemWrData,
  output logic        MemWe,
  output logic        MemRe,
  output logic        StackInEnable,
  output logic [15:0] StackIn,
  output logic        PCLoad,
  output logic [15:0] PCNext,
  output logic [7:0]  PopData,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam logic [15:0] CallLimit = STACK_LIMIT + 16'd1;
  localparam logic [15:0] RetTop    = STACK_TOP - 16'd1;

  state_t      r_state;
  state_t      w_next;
  op_t         r_op;
  logic [15:0] r_sp;
  logic [7:0]  r_data;
  logic [15:0] r_ret;
  logic [15:0] r_tgt;
  logic [7:0]  r_hi;
  logic [7:0]  r_lo;
  logic [7:0]  r_pop;
  logic        w_err;

  // Bounds check on the live inputs, used when a request is accepted
  always_comb begin
    w_err = 1'b0;
    unique case (op_t'(Op))
      OP_PUSH: w_err = SPIn < STACK_LIMIT;
      OP_CALL: w_err = SPIn < CallLimit;
      OP_POP:  w_err = SPIn >= STACK_TOP;
      OP_RET:  w_err = SPIn >= RetTop;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (w_err)
            w_next = S_ERR;
          else if (op_t'(Op) == OP_PUSH || op_t'(Op) == OP_CALL)
            w_next = S_W1;
          else
            w_next = S_R1;
        end
      end
      S_W1:   w_next = (r_op == OP_CALL) ? S_W2 : S_DONE;
      S_W2:   w_next = S_DONE;
      S_R1:   w_next = (r_op == OP_RET) ? S_R2 : S_RCAP;
      S_R2:   w_next = S_RCAP;
      S_RCAP: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      S_ERR:  w_next = S_IDLE;
    endcase
  end

  // Request latch and read-data capture
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_op   <= OP_PUSH;
      r_sp   <= '0;
      r_data <= '0;
      r_ret  <= '0;
      r_tgt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_pop  <= '0;
    end else begin
      if (r_state == S_IDLE && Start) begin
        r_op   <= op_t'(Op);
        r_sp   <= SPIn;
        r_data <= DataIn;
        r_ret  <= RetAddr;
        r_tgt  <= Target;
      end
      if (r_state == S_R2)
        r_hi <= MemRdData;
      // RET keeps its low byte private so PopData only moves on POP
      if (r_state == S_RCAP) begin
        if (r_op == OP_POP) r_pop <= MemRdData;
        else                r_lo  <= MemRdData;
      end
    end
  end

  always_comb begin
    MemAddr       = '0;
    MemWrData     = '0;
    MemWe         = 1'b0;
    MemRe         = 1'b0;
    StackInEnable = 1'b0;
    StackIn       = '0;
    PCLoad        = 1'b0;
    PCNext        = '0;
    Done          = 1'b0;
    Error         = 1'b0;
    Busy          = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: ;
      S_W1: begin
        MemWe     = 1'b1;
        MemAddr   = r_sp;
        MemWrData = (r_op == OP_CALL) ? r_ret[7:0] : r_data;
      end
      S_W2: begin
        MemWe     = 1'b1;
        MemAddr   = r_sp - 16'd1;
        MemWrData = r_ret[15:8];
      end
      S_R1: begin
        MemRe   = 1'b1;
        MemAddr = r_sp + 16'd1;
      end
      S_R2: begin
        MemRe   = 1'b1;
        MemAddr = r_sp + 16'd2;
      end
      S_RCAP: ;
      S_DONE: begin
        Done          = 1'b1;
        StackInEnable = 1'b1;
        unique case (r_op)
          OP_PUSH: StackIn = r_sp - 16'd1;
          OP_POP:  StackIn = r_sp + 16'd1;
          OP_CALL: begin
            StackIn = r_sp - 16'd2;
            PCLoad  = 1'b1;
            PCNext  = r_tgt;
          end
          OP_RET: begin
            StackIn = r_sp + 16'd2;
            PCLoad  = 1'b1;
            PCNext  = {r_hi, r_lo};
          end
        endcase
      end
      S_ERR: begin
        Done  = 1'b1;
        Error = 1'b1;
      end
    endcase
  end

  assign PopData = r_pop;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed cases plus random
// ops checked against a byte-stack reference model.
module tb_stack_sequencer;

  localparam int LIM = 32'h0100;
  localparam int TOP = 32'h08FF;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = '0;
  logic [7:0]  DataIn = '0;
  logic [15:0] SPIn = '0;
  logic [15:0] RetAddr = '0;
  logic [15:0] Target = '0;
  logic [7:0]  MemRdData = '0;
  logic [15:0] MemAddr;
  logic [7:0]  MemWrData;
  logic        MemWe;
  logic        MemRe;
  logic        StackInEnable;
  logic [15:0] StackIn;
  logic        PCLoad;
  logic [15:0] PCNext;
  logic [7:0]  PopData;
  logic        Busy;
  logic        Done;
  logic        Error;

  stack_sequencer dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Op(Op),
    .DataIn(DataIn), .SPIn(SPIn), .RetAddr(RetAddr),
    .Target(Target), .MemRdData(MemRdData), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemWe(MemWe), .MemRe(MemRe),
    .StackInEnable(StackInEnable), .StackIn(StackIn),
    .PCLoad(PCLoad), .PCNext(PCNext), .PopData(PopData),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] exp_pop = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] sp,
                        input logic [7:0] din, input logic [15:0] ret,
                        input logic [15:0] tgt, input bit hold);
    logic [15:0] ew_a[$];
    logic [7:0]  ew_d[$];
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    logic [15:0] msp, e_pc, osin, opc, paddr;
    logic [7:0]  hi, lo;
    bit e_err, e_pcl, oerr, pend;
    int e_lat, e_nre, nre, nsin, npc, lat, busy_bad;
    int s;
    s = int'(sp);
    e_err = (op == 2'b00 && s < LIM) || (op == 2'b10 && s < LIM + 1) ||
            (op == 2'b01 && s >= TOP) || (op == 2'b11 && s >= TOP - 1);
    msp = sp; e_pc = '0; e_pcl = 0; e_nre = 0;
    if (!e_err) begin
      case (op)
        2'b00: begin
          ew_a.push_back(msp); ew_d.push_back(din);
          ref_mem[msp] = din; msp = msp - 1;
        end
        2'b10: begin
          ew_a.push_back(msp); ew_d.push_back(ret[7:0]);
          ref_mem[msp] = ret[7:0]; msp = msp - 1;
          ew_a.push_back(msp); ew_d.push_back(ret[15:8]);
          ref_mem[msp] = ret[15:8]; msp = msp - 1;
          e_pcl = 1; e_pc = tgt;
        end
        2'b01: begin
          msp = msp + 1; exp_pop = ref_mem[msp]; e_nre = 1;
        end
        default: begin
          msp = msp + 1; hi = ref_mem[msp];
          msp = msp + 1; lo = ref_mem[msp];
          e_nre = 2; e_pcl = 1; e_pc = {hi, lo};
        end
      endcase
    end
    e_lat = e_err ? 1 : 1 + ew_a.size() + e_nre + (e_nre > 0 ? 1 : 0);

    @(negedge Clock);
    Op = op; SPIn = sp; DataIn = din; RetAddr = ret; Target = tgt;
    Start = 1'b1;
    @(posedge Clock); #1;
    if (!hold) Start = 1'b0;
    MemRdData = 8'($urandom);
    lat = 0; nre = 0; nsin = 0; npc = 0; busy_bad = 0;
    oerr = 0; osin = '0; opc = '0; pend = 0; paddr = '0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge Clock);
      if (MemWe) begin
        wa.push_back(MemAddr); wd.push_back(MemWrData);
        mem[MemAddr] = MemWrData;
      end
      pend = MemRe;
      if (MemRe) begin nre++; paddr = MemAddr; end
      if (StackInEnable) begin nsin++; osin = StackIn; end
      if (PCLoad) begin npc++; opc = PCNext; end
      if (!Busy) busy_bad++;
      if (Done) begin lat = c; oerr = Error; end
      @(posedge Clock); #1;
      MemRdData = pend ? mem[paddr] : 8'($urandom);
    end
    Start = 1'b0;
    @(negedge Clock);
    chk("latency", lat, e_lat);
    chk("error", 32'(oerr), 32'(e_err));
    chk("busy_during", busy_bad, 0);
    chk("idle_after", {30'd0, Busy, Done}, 0);
    chk("n_writes", wa.size(), ew_a.size());
    for (int i = 0; i < wa.size() && i < ew_a.size(); i++) begin
      chk("wr_addr", 32'(wa[i]), 32'(ew_a[i]));
      chk("wr_data", 32'(wd[i]), 32'(ew_d[i]));
    end
    chk("n_reads", nre, e_nre);
    chk("n_stackin", nsin, e_err ? 0 : 1);
    if (!e_err) chk("stackin", 32'(osin), 32'(msp));
    chk("n_pcload", npc, 32'(e_pcl));
    if (e_pcl) chk("pcnext", 32'(opc), 32'(e_pc));
    chk("popdata", 32'(PopData), 32'(exp_pop));
  endtask

  initial begin
    int pulses;
    logic [15:0] bnd [6];
    logic [15:0] sp;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'(a * 7 + 3);
      ref_mem[a] = mem[a];
    end
    bnd[0] = 16'h00FF; bnd[1] = 16'h0100; bnd[2] = 16'h0101;
    bnd[3] = 16'h08FD; bnd[4] = 16'h08FE; bnd[5] = 16'h08FF;

    #2;
    chk("reset_outs", {31'd0, |{MemAddr, MemWrData, MemWe, MemRe,
        StackInEnable, StackIn, PCLoad, PCNext, PopData, Busy,
        Done, Error}}, 0);
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;

    run_op(2'b00, 16'h08FF, 8'hA5, 16'h0, 16'h0, 0);
    run_op(2'b10, 16'h08FF, 8'h00, 16'h1234, 16'h0200, 0);
    run_op(2'b11, 16'h08FD, 8'h00, 16'h0, 16'h0, 0);
    run_op(2'b01, 16'h08FF, 8'h00, 16'h0, 16'h0, 0);
    run_op(2'b00, 16'h00FF, 8'h5A, 16'h0, 16'h0, 0);
    run_op(2'b01, 16'h08FE, 8'h00, 16'h0, 16'h0, 1);
    run_op(2'b10, 16'h0100, 8'h00, 16'hCAFE, 16'h0400, 1);
    run_op(2'b11, 16'h08FE, 8'h00, 16'h0, 16'h0, 0);

    // reset in the middle of a CALL, while in the high-byte write
    @(negedge Clock);
    Op = 2'b10; SPIn = 16'h0700; RetAddr = 16'hBEEF;
    Target = 16'h0300; Start = 1'b1;
    @(posedge Clock); #1 Start = 1'b0;
    @(negedge Clock);
    chk("abort_w1_we", {31'd0, MemWe}, 1);
    chk("abort_w1_data", {24'd0, MemWrData}, 32'h00EF);
    mem[16'h0700] = 8'hEF; ref_mem[16'h0700] = 8'hEF;
    @(posedge Clock); #2;
    ResetN = 1'b0;
    #1;
    chk("abort_outs", {31'd0, |{MemAddr, MemWrData, MemWe, MemRe,
        StackInEnable, StackIn, PCLoad, PCNext, PopData, Busy,
        Done}}, 0);
    exp_pop = 8'h00;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock);
      if (StackInEnable || PCLoad || MemWe || Done) pulses++;
      if (c == 2) ResetN = 1'b1;
    end
    chk("abort_pulses", pulses, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) sp = bnd[$urandom_range(0, 5)];
      else sp = 16'($urandom_range(32'h00F0, 32'h0910));
      run_op(2'($urandom_range(0, 3)), sp, 8'($urandom),
             16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter STACK_LIMIT, default 16'h0100, meaning lowest writable stack address.
REQ-002 SHALL have parameter STACK_TOP, default 16'h08FF, meaning highest stack address (empty-stack SP).
REQ-003 Clock  input  1  sole clock; all state changes on posedge.
REQ-004 ResetN  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 Start  input  1  request strobe, sampled only in IDLE.
REQ-006 Op  input  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
REQ-007 DataIn  input  8  byte to push.
REQ-008 SPIn  input  16  current stack pointer {SH,SL}.
REQ-009 RetAddr  input  16  return address for CALL.
REQ-010 Target  input  16  CALL destination.
REQ-011 MemRdData  input  8  data memory read data, valid the cycle after MemRe.
REQ-012 MemAddr  output  16; MemWrData  output  8; MemWe  output  1; MemRe  output  1  data memory port.
REQ-013 StackInEnable  output  1; StackIn  output  16  stack pointer write to register file.
REQ-014 PCLoad  output  1; PCNext  output  16  program counter load.
REQ-015 PopData  output  8  popped byte, held until next POP.
REQ-016 Busy  output  1; Done  output  1; Error  output  1  status.

Function
REQ-017 States SHALL be IDLE, W1, W2, R1, R2, RCAP, DONE, ERR.
REQ-018 In IDLE with Start=1: latch Op, SPIn (SPq), DataIn, RetAddr, Target; Busy=1 from next cycle through final DONE/ERR cycle inclusive.
REQ-019 Start outside IDLE SHALL be ignored; a new request is accepted no earlier than the cycle after Done.
REQ-020 PUSH: W1 drives MemWe=1, MemAddr=SPq, MemWrData=DataIn latched; DONE drives StackInEnable=1, StackIn=SPq-1, Done=1; Start-to-Done latency 2 cycles.
REQ-021 CALL: W1 writes RetAddr[7:0] at SPq; W2 writes RetAddr[15:8] at SPq-1; DONE drives StackIn=SPq-2, StackInEnable=1, PCLoad=1, PCNext=Target, Done=1; latency 3.
REQ-022 POP: R1 drives MemRe=1, MemAddr=SPq+1; RCAP captures MemRdData into PopData; DONE drives StackIn=SPq+1, StackInEnable=1, Done=1; latency 3.
REQ-023 RET: R1 reads SPq+1 (high byte); R2 captures high, reads SPq+2 (low byte); RCAP captures low; DONE drives PCLoad=1, PCNext={high,low}, StackIn=SPq+2, StackInEnable=1, Done=1; latency 4.
REQ-024 Overflow: PUSH with SPIn<STACK_LIMIT, or CALL with SPIn<STACK_LIMIT+1, SHALL go to ERR.
REQ-025 Underflow: POP with SPIn>=STACK_TOP, or RET with SPIn>=STACK_TOP-1, SHALL go to ERR.
REQ-026 ERR: one cycle Done=1, Error=1; no MemWe/MemRe, StackInEnable=0, PCLoad=0; then IDLE.
REQ-027 Address and SP arithmetic SHALL be 16-bit modulo 2^16.
REQ-028 MemWe, MemRe, StackInEnable, PCLoad, Done, Error SHALL be single-cycle pulses, 0 in all other states.
REQ-029 MemAddr, MemWrData, StackIn, PCNext SHALL be 0 when their strobe is low.

Reset
REQ-030 ResetN=0 SHALL force IDLE, all outputs 0, PopData=0, latched registers 0, immediately and asynchronously.
REQ-031 Reset mid-operation SHALL abandon the sequence with no further memory write, SP update or PC load.

Structure
REQ-032 Package stack_seq_pkg SHALL hold state encoding and Op codes (OP_PUSH, OP_POP, OP_CALL, OP_RET).
REQ-033 Single FSM module; no sub-module.

Verification
REQ-034 PUSH SPIn=0x08FF DataIn=0xA5 -> cycle1 write 0xA5 @0x08FF, cycle2 StackIn=0x08FE, Done.
REQ-035 CALL SPIn=0x08FF RetAddr=0x1234 Target=0x0200 -> writes 0x34 @0x08FF, 0x12 @0x08FE; DONE StackIn=0x08FD, PCNext=0x0200.
REQ-036 RET SPIn=0x08FD, mem[0x08FE]=0x12, mem[0x08FF]=0x34 -> PCNext=0x1234, StackIn=0x08FF, latency 4.
REQ-037 POP SPIn=0x08FF -> ERR, Error=1, no MemRe; PUSH SPIn=0x00FF -> ERR, no MemWe.
REQ-038 ResetN low during CALL W2 -> no StackInEnable/PCLoad ever pulsed; Start held high during Busy -> exactly one operation.
